// File: rtl/abc_toggle_gen_pkg.sv
// Shared types and helpers for the abc_toggle_gen stimulus source.
// The state encodings are fixed because gate-level and on-board runs compare against them.
package abc_toggle_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        return m;
    endfunction

endpackage

// File: rtl/toggle_div.sv
// Divide-by-DIV toggle channel: q inverts every DIV enabled cycles.
// clr takes priority over en so that launch and exit force a clean zero.
module toggle_div #(
    parameter int DIV = 1,
    parameter int W   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic q
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (en) begin
            if (cnt == W'(DIV - 1)) begin
                cnt <= '0;
                q   <= ~q;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/abc_toggle_gen.sv
// Cycle-exact a/b/c toggle stimulus for blocking_caveat, running RUN_LEN unheld cycles per start.
// The channel flops are the outputs themselves, so zero-forcing is done through their clr inputs.
module abc_toggle_gen
    import abc_toggle_gen_pkg::*;
#(
    parameter int DIV_A   = 1,
    parameter int DIV_B   = 5,
    parameter int DIV_C   = 10,
    parameter int RUN_LEN = 300,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DIV_W = $clog2(max3(DIV_A, DIV_B, DIV_C) + 1);

    if (DIV_A < 1 || DIV_B < 1 || DIV_C < 1) begin : g_bad_div
        $error("abc_toggle_gen: every DIV_x must be >= 1");
    end
    if (RUN_LEN < 1 || longint'(RUN_LEN) >= (longint'(1) << CNT_W)) begin : g_bad_len
        $error("abc_toggle_gen: RUN_LEN must be >= 1 and < 2**CNT_W");
    end

    state_t state;
    logic   launch;
    logic   last;
    logic   illegal;
    logic   clr;
    logic   en;

    assign launch  = (state == ST_IDLE) && start;
    assign last    = (state == ST_RUN) && !hold && (cycle_cnt == CNT_W'(RUN_LEN - 1));
    assign illegal = (state != ST_IDLE) && (state != ST_RUN) && (state != ST_DONE);
    assign clr     = launch || last || illegal;
    assign en      = (state == ST_RUN) && !hold;

    // cycle_cnt also advances on the exit edge, so it ends at RUN_LEN and stays there until restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        cycle_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                        if (last) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    toggle_div #(.DIV(DIV_A), .W(DIV_W)) u_div_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .q     (a)
    );

    toggle_div #(.DIV(DIV_B), .W(DIV_W)) u_div_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .q     (b)
    );

    toggle_div #(.DIV(DIV_C), .W(DIV_W)) u_div_c (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .q     (c)
    );

endmodule

// File: tb/tb_abc_toggle_gen.sv
// Bench for abc_toggle_gen: a default instance and a short DIV_A=3/RUN_LEN=12 instance share stimulus.
// Expected outputs come from a count of unheld RUN edges since launch: x = floor(k/DIV_x) mod 2.
module tb_abc_toggle_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic        hold;
    logic        a0, b0, c0, busy0, done0;
    logic        a1, b1, c1, busy1, done1;
    logic [15:0] cnt0, cnt1;

    int errors;
    int checks;

    int run_len [2];
    int div_tab [2][3];
    int m_phase [2];
    int m_k     [2];

    abc_toggle_gen #(.DIV_A(1), .DIV_B(5), .DIV_C(10), .RUN_LEN(300), .CNT_W(16)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hold      (hold),
        .a         (a0),
        .b         (b0),
        .c         (c0),
        .busy      (busy0),
        .done      (done0),
        .cycle_cnt (cnt0)
    );

    abc_toggle_gen #(.DIV_A(3), .DIV_B(5), .DIV_C(10), .RUN_LEN(12), .CNT_W(16)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .hold      (hold),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .busy      (busy1),
        .done      (done1),
        .cycle_cnt (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Phases: 0 idle, 1 running, 2 the single completion cycle.
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0;
            m_k[d]     = 0;
        end
    endtask

    task automatic model_edge(input logic s, input logic h);
        for (int d = 0; d < 2; d++) begin
            case (m_phase[d])
                0: if (s) begin
                    m_phase[d] = 1;
                    m_k[d]     = 0;
                end
                1: if (!h) begin
                    m_k[d] = m_k[d] + 1;
                    if (m_k[d] == run_len[d]) m_phase[d] = 2;
                end
                default: m_phase[d] = 0;
            endcase
        end
    endtask

    task automatic check_output(input string tag);
        logic [31:0] obs [6];
        logic [31:0] exp [6];
        string       names [6];
        bit          running;
        names = '{"a", "b", "c", "busy", "done", "cycle_cnt"};
        for (int d = 0; d < 2; d++) begin
            running = (m_phase[d] == 1);
            for (int ch = 0; ch < 3; ch++)
                exp[ch] = running ? 32'((m_k[d] / div_tab[d][ch]) % 2) : 32'd0;
            exp[3] = 32'(running);
            exp[4] = 32'(m_phase[d] == 2);
            exp[5] = 32'(m_k[d]);
            if (d == 0) obs = '{32'(a0), 32'(b0), 32'(c0), 32'(busy0), 32'(done0), 32'(cnt0)};
            else        obs = '{32'(a1), 32'(b1), 32'(c1), 32'(busy1), 32'(done1), 32'(cnt1)};
            for (int n = 0; n < 6; n++)
                check1($sformatf("%s.dut%0d.%s", tag, d, names[n]), obs[n], exp[n]);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic h, input string tag);
        start = s;
        hold  = h;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(s, h);
        #1;
        check_output(tag);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        run_len = '{300, 12};
        div_tab = '{'{1, 5, 10}, '{3, 5, 10}};
        model_reset();
        reset = 1'b1;
        start = 1'b1;
        hold  = 1'b0;

        $display("[TB] reset held with start high");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, "reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, "idle");

        $display("[TB] default run");
        apply_stimulus(1'b1, 1'b0, "launch");
        for (int i = 0; i < 305; i++) apply_stimulus(1'b0, 1'b0, "run");
        check1("final_cnt0", 32'(cnt0), 32'd300);

        $display("[TB] hold for 7 cycles at cycle_cnt 40");
        apply_stimulus(1'b1, 1'b0, "launch_h");
        for (int i = 0; i < 100 && cnt0 != 16'd40; i++) apply_stimulus(1'b0, 1'b0, "pre_hold");
        check1("reach_40", 32'(cnt0), 32'd40);
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b1, "hold");
        for (int i = 0; i < 265; i++) apply_stimulus(1'b0, 1'b0, "post_hold");

        $display("[TB] reset mid-run at cycle_cnt 150");
        apply_stimulus(1'b1, 1'b0, "launch_r");
        for (int i = 0; i < 200 && cnt0 != 16'd150; i++) apply_stimulus(1'b0, 1'b0, "pre_reset");
        check1("reach_150", 32'(cnt0), 32'd150);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_output("async_reset");
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, "after_reset");
        apply_stimulus(1'b1, 1'b0, "relaunch");
        for (int i = 0; i < 303; i++) apply_stimulus(1'b0, 1'b0, "rerun");

        $display("[TB] short instance with starts during RUN and DONE");
        for (int i = 0; i < 20; i++)
            apply_stimulus((i == 0) || (i == 5) || (i == 13), 1'b0, "short");

        $display("[TB] random start/hold");
        for (int i = 0; i < 700; i++)
            apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, "rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
